// File: rtl/vga_bram_scanout_if.sv
// Read-only port between the scan-out engine and the frame-buffer BRAM.
// Read data is valid one clock after en.
interface vga_bram_scanout_if #(
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 12
);
  logic              en;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  dout;

  modport master (output en, output addr, input dout);
  modport slave  (input en, input addr, output dout);
endinterface

// File: rtl/vga_bram_scanout.sv
// VGA scan-out engine: pixel-tick timing, replicated frame-buffer fetch and
// a two-stage pipeline driving RGB444 and syncs.
module vga_bram_scanout #(
  parameter int   H_ACTIVE    = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_ACTIVE    = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter int   CLK_DIV     = 4,
  parameter int   SCALE_SHIFT = 2,
  parameter int   ADDR_W      = 15,
  parameter int   PIX_W       = 12,
  parameter logic SYNC_POL    = 1'b0
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                ctrl_enable,
  input  logic [ADDR_W-1:0]   ctrl_base_addr,
  vga_bram_scanout_if.master  bram,
  output logic [3:0]          vga_r,
  output logic [3:0]          vga_g,
  output logic [3:0]          vga_b,
  output logic                vga_hs,
  output logic                vga_vs,
  output logic                frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0]     DIV_LAST     = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0]     H_LAST       = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0]     V_LAST       = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0]     H_ACT_C      = HW'(H_ACTIVE);
  localparam logic [VW-1:0]     V_ACT_C      = VW'(V_ACTIVE);
  localparam logic [HW-1:0]     H_SYNC_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     H_SYNC_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0]     V_SYNC_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     V_SYNC_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0]     GRP_MASK     = VW'((1 << SCALE_SHIFT) - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP     = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  // Tick generator and raster counters
  logic [DW-1:0]     div_cnt_reg;
  logic [HW-1:0]     h_cnt_reg, h_cnt_next;
  logic [VW-1:0]     v_cnt_reg, v_cnt_next;

  // Frame-latched controls and row pointer
  logic              en_lat_reg;
  logic [ADDR_W-1:0] row_addr_reg;
  logic              frame_start_reg;

  // Stage 0: issue
  logic              bram_en_reg;
  logic [ADDR_W-1:0] bram_addr_reg;
  logic              vis_s0_reg;
  logic              hs_s0_reg;
  logic              vs_s0_reg;

  // Stage 1: pins
  logic              hs_reg;
  logic              vs_reg;
  logic [PIX_W-1:0]  rgb_reg;

  logic              pix_tick;
  logic              h_last;
  logic              v_last;
  logic              frame_wrap;
  logic              active;
  logic              row_adv;
  logic              hs_on;
  logic              vs_on;
  logic [ADDR_W-1:0] issue_addr;

  assign pix_tick   = (div_cnt_reg == DIV_LAST);
  assign h_last     = (h_cnt_reg == H_LAST);
  assign v_last     = (v_cnt_reg == V_LAST);
  assign frame_wrap = pix_tick & h_last & v_last;
  assign active     = (h_cnt_reg < H_ACT_C) & (v_cnt_reg < V_ACT_C);
  assign hs_on      = (h_cnt_reg >= H_SYNC_START) & (h_cnt_reg < H_SYNC_END);
  assign vs_on      = (v_cnt_reg >= V_SYNC_START) & (v_cnt_reg < V_SYNC_END);
  // Step to the next frame-buffer row after the last replicated copy of a line
  assign row_adv    = pix_tick & h_last & (v_cnt_reg < V_ACT_C) &
                      ((v_cnt_reg & GRP_MASK) == GRP_MASK);
  assign issue_addr = row_addr_reg + ADDR_W'(h_cnt_reg >> SCALE_SHIFT);

  always_comb begin
    h_cnt_next = h_cnt_reg + 1'b1;
    v_cnt_next = v_cnt_reg;
    if (h_last) begin
      h_cnt_next = '0;
      v_cnt_next = v_last ? '0 : v_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      div_cnt_reg <= '0;
      h_cnt_reg   <= '0;
      v_cnt_reg   <= '0;
    end else begin
      div_cnt_reg <= pix_tick ? '0 : div_cnt_reg + 1'b1;
      if (pix_tick) begin
        h_cnt_reg <= h_cnt_next;
        v_cnt_reg <= v_cnt_next;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      en_lat_reg      <= 1'b0;
      row_addr_reg    <= '0;
      frame_start_reg <= 1'b0;
    end else begin
      frame_start_reg <= frame_wrap;
      if (frame_wrap) begin
        en_lat_reg   <= ctrl_enable;
        row_addr_reg <= ctrl_base_addr;
      end else if (row_adv) begin
        row_addr_reg <= row_addr_reg + ROW_STEP;
      end
    end
  end

  // Enable is a single-clock strobe per tick so the read port idles between pixels
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      bram_en_reg   <= 1'b0;
      bram_addr_reg <= '0;
      vis_s0_reg    <= 1'b0;
      hs_s0_reg     <= ~SYNC_POL;
      vs_s0_reg     <= ~SYNC_POL;
    end else begin
      bram_en_reg <= pix_tick & active & en_lat_reg;
      if (pix_tick) begin
        bram_addr_reg <= issue_addr;
        vis_s0_reg    <= active & en_lat_reg;
        hs_s0_reg     <= hs_on ? SYNC_POL : ~SYNC_POL;
        vs_s0_reg     <= vs_on ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  // Read data settled one clock after issue, well before this tick
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      hs_reg  <= ~SYNC_POL;
      vs_reg  <= ~SYNC_POL;
      rgb_reg <= '0;
    end else if (pix_tick) begin
      hs_reg  <= hs_s0_reg;
      vs_reg  <= vs_s0_reg;
      rgb_reg <= vis_s0_reg ? bram.dout : '0;
    end
  end

  logic [3:0] chan [3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign chan[gi] = rgb_reg[gi*4 +: 4];
    end
  endgenerate

  assign vga_b       = chan[0];
  assign vga_g       = chan[1];
  assign vga_r       = chan[2];
  assign vga_hs      = hs_reg;
  assign vga_vs      = vs_reg;
  assign frame_start = frame_start_reg;
  assign bram.en     = bram_en_reg;
  assign bram.addr   = bram_addr_reg;

endmodule

// File: tb/tb_vga_bram_scanout.sv
// Directed bench for vga_bram_scanout using a reduced raster (24x13 ticks,
// 16x8 visible, 4x2 frame buffer) so several frames fit in a short run.
module tb_vga_bram_scanout;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int CD = 4;
  localparam int FRAME_CYC = HT * VT * CD;
  localparam int LINE_CYC  = HT * CD;

  logic        aclk;
  logic        aresetn;
  logic        ctrl_enable;
  logic [14:0] ctrl_base_addr;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_start;

  vga_bram_scanout_if #(.ADDR_W(15), .PIX_W(12)) bram ();

  vga_bram_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .SCALE_SHIFT(2), .ADDR_W(15), .PIX_W(12), .SYNC_POL(1'b0)
  ) dut (
    .ACLK(aclk),
    .ARESETN(aresetn),
    .ctrl_enable(ctrl_enable),
    .ctrl_base_addr(ctrl_base_addr),
    .bram(bram),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hs(vga_hs),
    .vga_vs(vga_vs),
    .frame_start(frame_start)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // BRAM model: data is the low 12 address bits
  always @(posedge aclk) begin
    if (bram.en) bram.dout <= bram.addr[11:0];
  end

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [14:0] addr_q [$];
  logic        en_prev = 1'b0;
  int          en_long = 0;
  always @(negedge aclk) begin
    if (aresetn && bram.en) addr_q.push_back(bram.addr);
    if (aresetn && bram.en && en_prev) en_long <= en_long + 1;
    en_prev <= bram.en;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge aclk);
  endtask

  task automatic wait_fs(output int at);
    int n;
    n = 0;
    do begin
      @(negedge aclk);
      n++;
    end while (!frame_start && n < FRAME_CYC + 800);
    at = cyc;
    checks++;
    assert (frame_start === 1'b1)
    else begin
      failures++;
      $error("FAIL fs_timeout: got frame_start=%0b after %0d cycles, expected 1", frame_start, n);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [14:0] base);
    logic [14:0] exp;
    chk({tag, "_count"}, addr_q.size(), VA * HA);
    if (addr_q.size() == VA * HA) begin
      for (int v = 0; v < VA; v++) begin
        for (int h = 0; h < HA; h++) begin
          exp = base + 15'((v >> 2) * (HA >> 2)) + 15'(h >> 2);
          chk($sformatf("%s_v%0d_h%0d", tag, v, h), addr_q[v*HA + h], exp);
        end
      end
    end
    addr_q.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_bram_en"}, bram.en, 0);
    chk({tag, "_bram_addr"}, bram.addr, 0);
    chk({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
    chk({tag, "_hs"}, vga_hs, 1);
    chk({tag, "_vs"}, vga_vs, 1);
    chk({tag, "_fs"}, frame_start, 0);
  endtask

  int r0, r1, f1, f2, f3, f4, f5, f6;

  initial begin
    aresetn        = 1'b0;
    ctrl_enable    = 1'b1;
    ctrl_base_addr = 15'h0000;
    #200;
    chk_reset_outputs("reset");

    @(negedge aclk);
    aresetn = 1'b1;
    r0 = cyc;

    // First frame after reset runs with the reset-latched enable of 0
    wait_fs(f1);
    chk("first_fs_delay", f1 - r0, FRAME_CYC);
    chk("no_reads_pre_frame", addr_q.size(), 0);

    // Pixel x of line y reaches the pins at f + (2 + y*HT + x)*CD
    wait_cyc(f1 + 9);   chk("pix_l0_x0",  {vga_r, vga_g, vga_b}, 12'h000);
    wait_cyc(f1 + 29);  chk("pix_l0_x5",  {vga_r, vga_g, vga_b}, 12'h001);
    wait_cyc(f1 + 69);  chk("pix_l0_x15", {vga_r, vga_g, vga_b}, 12'h003);
    wait_cyc(f1 + 73);  chk("blank_l0_x16", {vga_r, vga_g, vga_b}, 12'h000);
    wait_cyc(f1 + 79);  chk("hs_before", vga_hs, 1);
    wait_cyc(f1 + 80);  chk("hs_fall", vga_hs, 0);
    wait_cyc(f1 + 91);  chk("hs_last_low", vga_hs, 0);
    wait_cyc(f1 + 92);  chk("hs_rise", vga_hs, 1);
    wait_cyc(f1 + 80 + LINE_CYC - 1); chk("hs_next_before", vga_hs, 1);
    wait_cyc(f1 + 80 + LINE_CYC);     chk("hs_next_fall", vga_hs, 0);
    wait_cyc(f1 + 393); chk("pix_l4_x0",  {vga_r, vga_g, vga_b}, 12'h004);
    wait_cyc(f1 + 741); chk("pix_l7_x15", {vga_r, vga_g, vga_b}, 12'h007);
    wait_cyc(f1 + 871); chk("vs_before", vga_vs, 1);
    wait_cyc(f1 + 872); chk("vs_fall", vga_vs, 0);
    wait_cyc(f1 + 1063); chk("vs_last_low", vga_vs, 0);
    wait_cyc(f1 + 1064); chk("vs_rise", vga_vs, 1);

    wait_fs(f2);
    chk("fs_period", f2 - f1, FRAME_CYC);
    chk_frame("frame1", 15'h0000);

    // Mid-frame control changes must not disturb the frame in flight
    wait_cyc(f2 + 600);
    ctrl_enable    = 1'b0;
    ctrl_base_addr = 15'h7FFC;
    wait_fs(f3);
    chk("fs_period2", f3 - f2, FRAME_CYC);
    chk_frame("frame2", 15'h0000);

    wait_cyc(f3 + 29); chk("disabled_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    wait_cyc(f3 + 80); chk("disabled_hs", vga_hs, 0);
    wait_cyc(f3 + 600);
    ctrl_enable = 1'b1;
    wait_fs(f4);
    chk("disabled_no_reads", addr_q.size(), 0);
    addr_q.delete();

    wait_cyc(f4 + 9);   chk("wrap_pix_l0_x0", {vga_r, vga_g, vga_b}, 12'hFFC);
    wait_cyc(f4 + 409); chk("wrap_pix_l4_x4", {vga_r, vga_g, vga_b}, 12'h001);
    wait_fs(f5);
    chk_frame("frame4_wrap", 15'h7FFC);

    // Reset during an active line aborts immediately
    wait_cyc(f5 + 317); chk("pre_reset_pix", {vga_r, vga_g, vga_b}, 12'hFFD);
    #2;
    aresetn = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    #100;
    @(negedge aclk);
    aresetn = 1'b1;
    r1 = cyc;
    addr_q.delete();
    wait_fs(f6);
    chk("restart_fs_delay", f6 - r1, FRAME_CYC);
    chk("restart_no_reads", addr_q.size(), 0);
    chk("bram_en_single_cycle", en_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
